demux16_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 1-to-16 demultiplexer datapath. Sixteen sinks request service. The block grants one sink at a time, drives the demux select, and paces a valid/ready stream from the single source into the granted sink for a bounded burst. Fairness comes from a rotating priority pointer, so one sink cannot monopolise the shared source.

---
 rtl/demux16_arbiter.sv | 106 ++++++++++
 tb/tb_demux16_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/demux16_arbiter.sv
// Round-robin arbiter/sequencer granting one of 16 sinks a bounded burst from a shared valid/ready source.
// Latency: req -> gnt one cycle; termination -> burst_done/IDLE one cycle. Source is stalled (in_ready=0) outside GRANT.
module demux16_arbiter #(
    parameter int BURST = 4,
    parameter int CW    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  sel,
    output logic [15:0] gnt,
    output logic        busy,
    output logic        burst_done
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    sel_q, sel_d;
    logic [3:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    logic          win_found;
    logic [3:0]    win_idx;
    logic [3:0]    scan_idx;
    logic          beat;
    logic          last_beat;

    // Scan starts at ptr and wraps naturally through the 4-bit add.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 4'd0;
        scan_idx  = 4'd0;
        for (int k = 0; k < 16; k++) begin
            scan_idx = ptr_q + 4'(k);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign beat      = (state_q == S_GRANT) && in_valid;
    assign last_beat = beat && (cnt_q == CW'(BURST - 1));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    sel_d   = win_idx;
                    cnt_d   = '0;
                end
            end
            S_GRANT: begin
                if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // A beat coinciding with a dropped request is still taken.
                if (last_beat || !req[sel_q]) begin
                    state_d = S_IDLE;
                    ptr_d   = sel_q + 4'd1;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= 4'd0;
            ptr_q   <= 4'd0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy       = (state_q == S_GRANT);
    assign in_ready   = busy;
    assign gnt        = busy ? (16'h0001 << sel_q) : 16'h0000;
    assign sel        = sel_q;
    assign burst_done = done_q;

endmodule

// File: tb/tb_demux16_arbiter.sv
// Self-checking bench for demux16_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_demux16_arbiter;

    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        busy;
    logic        burst_done;

    int checks   = 0;
    int failures = 0;

    // Reference model: "who owns the source and how many beats it has had".
    bit  m_owned;
    int  m_owner;
    int  m_next_first;
    int  m_taken;
    bit  m_done;

    int  beats;
    bit  prev_busy;
    int  grant_starts[$];

    demux16_arbiter #(.BURST(BURST), .CW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .gnt        (gnt),
        .busy       (busy),
        .burst_done (burst_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owned      = 1'b0;
        m_owner      = 0;
        m_next_first = 0;
        m_taken      = 0;
        m_done       = 1'b0;
    endtask

    // One cycle: drive at negedge, compare outputs to model, advance model for the coming edge.
    task automatic step(input logic r, input logic [15:0] rq, input logic v);
        @(negedge clk);
        rst      = r;
        req      = rq;
        in_valid = v;
        #1;
        chk("gnt",        32'(gnt),        m_owned ? 32'(16'h0001 << m_owner) : 32'd0);
        chk("sel",        32'(sel),        32'(m_owner));
        chk("busy",       32'(busy),       32'(m_owned));
        chk("in_ready",   32'(in_ready),   32'(m_owned));
        chk("burst_done", 32'(burst_done), 32'(m_done));
        if (in_ready && v) beats++;
        if (busy && !prev_busy) grant_starts.push_back(int'(sel));
        prev_busy = busy;
        if (r) begin
            model_reset();
        end else if (!m_owned) begin
            m_done = 1'b0;
            for (int k = 0; k < 16; k++) begin
                if (!m_owned && rq[(m_next_first + k) % 16]) begin
                    m_owned = 1'b1;
                    m_owner = (m_next_first + k) % 16;
                    m_taken = 0;
                end
            end
        end else begin
            m_taken = m_taken + (v ? 1 : 0);
            if (m_taken == BURST || !rq[m_owner]) begin
                m_owned      = 1'b0;
                m_next_first = (m_owner + 1) % 16;
                m_taken      = 0;
                m_done       = 1'b1;
            end else begin
                m_done = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        step(1'b1, 16'h0000, 1'b0);
        step(1'b1, 16'h0000, 1'b0);
    endtask

    initial begin
        int exp_order[5];
        logic [15:0] rq;
        exp_order = '{0, 1, 15, 0, 1};
        rst       = 1'b1;
        req       = 16'hFFFF;
        in_valid  = 1'b1;
        prev_busy = 1'b0;
        beats     = 0;
        model_reset();
        @(posedge clk);

        // Reset with everything requesting.
        step(1'b1, 16'hFFFF, 1'b1);
        step(1'b1, 16'hFFFF, 1'b1);
        step(1'b0, 16'hFFFF, 1'b1);
        chk("rst_rel_gnt", 32'(gnt), 32'd0);
        step(1'b0, 16'hFFFF, 1'b1);
        chk("rst_first_gnt", 32'(gnt), 32'h0001);

        // Single requester full burst then regrant.
        do_reset();
        step(1'b0, 16'h0020, 1'b1);
        beats = 0;
        for (int i = 0; i < BURST; i++) begin
            step(1'b0, 16'h0020, 1'b1);
            chk("single_gnt", 32'(gnt), 32'h0020);
            chk("single_sel", 32'(sel), 32'd5);
        end
        chk("single_beats", 32'(beats), 32'd4);
        step(1'b0, 16'h0020, 1'b1);
        chk("single_done", 32'(burst_done), 32'd1);
        chk("single_idle", 32'(busy), 32'd0);
        step(1'b0, 16'h0020, 1'b1);
        chk("single_regrant", 32'(gnt), 32'h0020);

        // Round-robin with wrap.
        do_reset();
        grant_starts.delete();
        for (int i = 0; i < 26; i++) step(1'b0, 16'h8003, 1'b1);
        chk("rr_count", 32'(grant_starts.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_starts.size()) chk("rr_order", 32'(grant_starts[i]), 32'(exp_order[i]));
        end

        // Early release with a beat on the drop cycle.
        do_reset();
        step(1'b0, 16'h0008, 1'b1);
        beats = 0;
        step(1'b0, 16'h0008, 1'b1);
        step(1'b0, 16'h0008, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        chk("early_v1_beats", 32'(beats), 32'd3);
        step(1'b0, 16'h8018, 1'b0);
        chk("early_v1_busy", 32'(busy), 32'd0);
        chk("early_v1_done", 32'(burst_done), 32'd1);
        step(1'b0, 16'h8018, 1'b0);
        chk("early_v1_ptr", 32'(sel), 32'd4);

        // Early release without a beat on the drop cycle.
        do_reset();
        step(1'b0, 16'h0008, 1'b1);
        beats = 0;
        step(1'b0, 16'h0008, 1'b1);
        step(1'b0, 16'h0008, 1'b1);
        step(1'b0, 16'h0000, 1'b0);
        chk("early_v0_beats", 32'(beats), 32'd2);
        step(1'b0, 16'h0000, 1'b0);
        chk("early_v0_busy", 32'(busy), 32'd0);

        // Stalled source.
        do_reset();
        step(1'b0, 16'h0080, 1'b0);
        beats = 0;
        begin
            logic [6:0] vpat;
            vpat = 7'b1011001;
            for (int i = 0; i < 7; i++) begin
                step(1'b0, 16'h0080, vpat[i]);
                chk("stall_gnt", 32'(gnt), 32'h0080);
            end
        end
        chk("stall_beats", 32'(beats), 32'd4);
        step(1'b0, 16'h0000, 1'b0);
        chk("stall_end", 32'(busy), 32'd0);
        chk("stall_done", 32'(burst_done), 32'd1);

        // Reset mid-burst.
        do_reset();
        step(1'b0, 16'h0400, 1'b1);
        step(1'b0, 16'h0400, 1'b1);
        step(1'b0, 16'h0400, 1'b1);
        step(1'b1, 16'h0401, 1'b1);
        step(1'b0, 16'h0401, 1'b1);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_done", 32'(burst_done), 32'd0);
        step(1'b0, 16'h0401, 1'b1);
        chk("midrst_restart", 32'(sel), 32'd0);

        // Randomized traffic.
        do_reset();
        rq = 16'h0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 16'($urandom) & 16'($urandom);
            step(($urandom_range(0, 99) == 0), rq, 1'($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
